usbd_report_encoder: RTL and testbench

Converts the 8-bit NES button state into an 8-byte darfon/dragonrise-format USB HID joystick report. It is the inverse of the host-side report decoder. It serializes the report byte-wise onto a valid/ready stream towards the USB device endpoint core. Reports are sent on button change, rate-limited to one per poll interval, and re-sent on an idle timeout. It is used for USB device mode and for host/decoder loopback testing.

---
 rtl/usb_report_pkg.sv | 63 ++++++
 rtl/usb_report_pack.sv | 60 ++++++
 rtl/usbd_report_encoder.sv | 133 +++++++++++++
 tb/tb_usbd_report_encoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_report_pkg.sv
// ============================================================================
//  usb_report_pkg
//  Shared constants for the darfon/dragonrise 8-byte joystick report.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package usb_report_pkg;

  // Byte positions inside the 64-bit report (byte0 = report[7:0])
  localparam int c_byte_x   = 0;
  localparam int c_byte_y   = 1;
  localparam int c_byte_z   = 2;
  localparam int c_byte_rz  = 3;
  localparam int c_byte_aux = 4;
  localparam int c_byte_btn = 5;
  localparam int c_byte_sys = 6;
  localparam int c_byte_pad = 7;

  localparam logic [7:0] c_axis_min = 8'h00;
  localparam logic [7:0] c_axis_mid = 8'h80;
  localparam logic [7:0] c_axis_max = 8'hFF;

  localparam logic [3:0] c_hat_up    = 4'd0;
  localparam logic [3:0] c_hat_ur    = 4'd1;
  localparam logic [3:0] c_hat_right = 4'd2;
  localparam logic [3:0] c_hat_dr    = 4'd3;
  localparam logic [3:0] c_hat_down  = 4'd4;
  localparam logic [3:0] c_hat_dl    = 4'd5;
  localparam logic [3:0] c_hat_left  = 4'd6;
  localparam logic [3:0] c_hat_ul    = 4'd7;
  localparam logic [3:0] c_hat_null  = 4'hF;

  // NES button bit order, identical to the host-side decoder output
  localparam int c_btn_a      = 0;
  localparam int c_btn_b      = 1;
  localparam int c_btn_select = 2;
  localparam int c_btn_start  = 3;
  localparam int c_btn_up     = 4;
  localparam int c_btn_down   = 5;
  localparam int c_btn_left   = 6;
  localparam int c_btn_right  = 7;

  localparam logic [63:0] c_idle_report = 64'h0000_0F80_8080_8080;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Opposing directions cancel to the centre value
  function automatic logic [7:0] axis_byte(input logic neg, input logic pos);
    case ({neg, pos})
      2'b10:   return c_axis_min;
      2'b01:   return c_axis_max;
      default: return c_axis_mid;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_report_pack.sv
// ============================================================================
//  usb_report_pack
//  Combinational NES button byte -> 64-bit joystick report.
//  Optional macro: USBD_REPORT_HAT_EN (d-pad also drives the hat nibble).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module usb_report_pack
  import usb_report_pkg::*;
(
  input  logic [7:0]  btn,
  output logic [63:0] report
);

  logic [3:0] hat;
  logic [7:0] byte_x;
  logic [7:0] byte_y;
  logic [7:0] byte_btn;
  logic [7:0] byte_sys;

`ifdef USBD_REPORT_HAT_EN
  always_comb begin
    hat = c_hat_null;
    case ({btn[c_btn_up], btn[c_btn_down], btn[c_btn_left], btn[c_btn_right]})
      4'b1000: hat = c_hat_up;
      4'b1001: hat = c_hat_ur;
      4'b0001: hat = c_hat_right;
      4'b0101: hat = c_hat_dr;
      4'b0100: hat = c_hat_down;
      4'b0110: hat = c_hat_dl;
      4'b0010: hat = c_hat_left;
      4'b1010: hat = c_hat_ul;
      default: hat = c_hat_null;
    endcase
  end
`else
  assign hat = c_hat_null;
`endif

  assign byte_x   = axis_byte(btn[c_btn_left], btn[c_btn_right]);
  assign byte_y   = axis_byte(btn[c_btn_up], btn[c_btn_down]);
  assign byte_btn = {1'b0, btn[c_btn_a], btn[c_btn_b], 1'b0, hat};
  assign byte_sys = {2'b00, btn[c_btn_start], btn[c_btn_select], 4'b0000};

  always_comb begin
    report = '0;
    report[c_byte_x*8   +: 8] = byte_x;
    report[c_byte_y*8   +: 8] = byte_y;
    report[c_byte_z*8   +: 8] = c_axis_mid;
    report[c_byte_rz*8  +: 8] = c_axis_mid;
    report[c_byte_aux*8 +: 8] = c_axis_mid;
    report[c_byte_btn*8 +: 8] = byte_btn;
    report[c_byte_sys*8 +: 8] = byte_sys;
    report[c_byte_pad*8 +: 8] = 8'h00;
  end

endmodule

`default_nettype wire

// File: rtl/usbd_report_encoder.sv
// ============================================================================
//  usbd_report_encoder
//  Serializes NES button state as rate-limited 8-byte HID joystick reports.
//  Optional macro: USBD_REPORT_HAT_EN (passed through to usb_report_pack).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module usbd_report_encoder
  import usb_report_pkg::*;
#(
  parameter int c_clk_hz      = 6000000,
  parameter int c_interval_us = 1000,
  parameter int c_idle_ms     = 500
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_btn,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_tx_last,
  input  logic        i_tx_ready,
  output logic [63:0] o_report,
  output logic        o_busy
);

  localparam longint c_gap_cycles  = (longint'(c_clk_hz) * longint'(c_interval_us)) / 1000000;
  localparam longint c_idle_cycles = (longint'(c_clk_hz) / 1000) * longint'(c_idle_ms);

  localparam int c_gap_w  = (c_gap_cycles  > 0) ? $clog2(c_gap_cycles  + 1) : 1;
  localparam int c_idle_w = (c_idle_cycles > 0) ? $clog2(c_idle_cycles + 1) : 1;

  localparam logic [c_gap_w-1:0]  c_gap_max  = c_gap_w'(c_gap_cycles);
  localparam logic [c_gap_w-1:0]  c_gap_one  = (c_gap_cycles > 0) ? c_gap_w'(1) : '0;
  localparam logic [c_gap_w-1:0]  c_gap_exit = (c_gap_cycles > 0) ? c_gap_w'(c_gap_cycles - 1) : '0;
  localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(c_idle_cycles);
  localparam logic [c_idle_w-1:0] c_idle_one = (c_idle_cycles > 0) ? c_idle_w'(1) : '0;

  state_t              state;
  logic [7:0]          btn_q;
  logic [2:0]          idx;
  logic [2:0]          idx_nx;
  logic                pending;
  logic [c_gap_w-1:0]  gap_cnt;
  logic [c_idle_w-1:0] idle_cnt;
  logic [63:0]         packed_report;
  logic                gap_done;
  logic                idle_expired;
  logic                send_req;

  usb_report_pack u_pack (
    .btn    (btn_q),
    .report (packed_report)
  );

  // Counters are loaded with 1 on SEND entry so that both the interval and
  // the idle period measure start-to-start distance in whole cycles.
  assign idx_nx       = idx + 3'd1;
  assign gap_done     = (gap_cnt >= c_gap_exit);
  assign idle_expired = (c_idle_cycles != 0) && (idle_cnt >= c_idle_max);
  assign send_req     = pending || (packed_report != o_report) || idle_expired;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      btn_q      <= '0;
      idx        <= '0;
      pending    <= 1'b1;
      gap_cnt    <= '0;
      idle_cnt   <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_tx_last  <= 1'b0;
      o_busy     <= 1'b0;
      o_report   <= c_idle_report;
    end else begin
      btn_q <= i_btn;

      if (gap_cnt != c_gap_max) begin
        gap_cnt <= gap_cnt + c_gap_w'(1);
      end
      if (idle_cnt != c_idle_max) begin
        idle_cnt <= idle_cnt + c_idle_w'(1);
      end

      case (state)
        ST_IDLE: begin
          if (send_req) begin
            o_report   <= packed_report;
            pending    <= 1'b0;
            idx        <= '0;
            gap_cnt    <= c_gap_one;
            idle_cnt   <= c_idle_one;
            o_tx_data  <= packed_report[7:0];
            o_tx_valid <= 1'b1;
            o_tx_last  <= 1'b0;
            o_busy     <= 1'b1;
            state      <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (o_tx_valid && i_tx_ready) begin
            if (idx == 3'd7) begin
              o_tx_data  <= '0;
              o_tx_valid <= 1'b0;
              o_tx_last  <= 1'b0;
              o_busy     <= 1'b0;
              state      <= (c_gap_cycles == 0) ? ST_IDLE : ST_GAP;
            end else begin
              idx       <= idx_nx;
              o_tx_data <= o_report[{idx_nx, 3'b000} +: 8];
              o_tx_last <= (idx_nx == 3'd7);
            end
          end
        end

        ST_GAP: begin
          if (gap_done) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usbd_report_encoder.sv
// ============================================================================
//  tb_usbd_report_encoder
//  Directed self-checking bench for usbd_report_encoder.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_usbd_report_encoder;

  localparam logic [63:0] c_idle_rep = 64'h0000_0F80_8080_8080;
  localparam logic [63:0] c_rep_ra   = 64'h0000_4F80_8080_80FF;
  localparam logic [63:0] c_rep_ss   = 64'h0030_0F80_8080_8080;
  localparam logic [63:0] c_rep_a    = 64'h0000_4F80_8080_8080;
  localparam logic [63:0] c_rep_b    = 64'h0000_2F80_8080_8080;
`ifdef USBD_REPORT_HAT_EN
  localparam logic [63:0] c_rep_u    = 64'h0000_0080_8080_0080;
`else
  localparam logic [63:0] c_rep_u    = 64'h0000_0F80_8080_0080;
`endif

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic [7:0]  btn = 8'h00;
  logic        rdy = 1'b1;
  logic        tog = 1'b0;

  logic [7:0]  a_data, b_data;
  logic        a_valid, b_valid, a_last, b_last, a_busy, b_busy;
  logic [63:0] a_report, b_report;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int xfers = 0;

  logic [63:0] frames_a[$];
  int          starts_a[$];
  logic [63:0] frames_b[$];
  int          starts_b[$];

  usbd_report_encoder dut_a (
    .i_clk      (clk),
    .i_reset    (rst_a),
    .i_btn      (btn),
    .o_tx_data  (a_data),
    .o_tx_valid (a_valid),
    .o_tx_last  (a_last),
    .i_tx_ready (rdy),
    .o_report   (a_report),
    .o_busy     (a_busy)
  );

  usbd_report_encoder #(.c_idle_ms(1)) dut_b (
    .i_clk      (clk),
    .i_reset    (rst_b),
    .i_btn      (8'h10),
    .o_tx_data  (b_data),
    .o_tx_valid (b_valid),
    .o_tx_last  (b_last),
    .i_tx_ready (1'b1),
    .o_report   (b_report),
    .o_busy     (b_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fa(input int i);
    return (i < frames_a.size()) ? frames_a[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic int sa(input int i);
    return (i < starts_a.size()) ? starts_a[i] : -100000;
  endfunction

  function automatic logic [63:0] fb(input int i);
    return (i < frames_b.size()) ? frames_b[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic int sb(input int i);
    return (i < starts_b.size()) ? starts_b[i] : -100000;
  endfunction

  task automatic wait_frame(input int n, input int budget, input string tag);
    int k = 0;
    while (frames_a.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(frames_a.size() >= n), 64'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (tog) rdy = ~rdy;
  end

  // Frame collector for dut_a: assembles bytes, checks last flag and hold stability
  initial begin
    int          nb = 0;
    int          rise = 0;
    logic        prev_v = 1'b0;
    logic        hold = 1'b0;
    logic [7:0]  hd = 8'h00;
    logic        hl = 1'b0;
    logic [63:0] cur = '0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        nb = 0;
        hold = 1'b0;
        prev_v = 1'b0;
      end else begin
        if (a_valid && !prev_v) rise = cyc;
        if (hold && a_valid) begin
          chk("hold_data", 64'(a_data), 64'(hd));
          chk("hold_last", 64'(a_last), 64'(hl));
        end
        hold = a_valid && !rdy;
        hd = a_data;
        hl = a_last;
        if (a_busy) busy_cnt++;
        if (a_valid && rdy) begin
          chk("last_flag", 64'(a_last), 64'(nb == 7));
          cur[nb*8 +: 8] = a_data;
          xfers++;
          if (nb == 7) begin
            frames_a.push_back(cur);
            starts_a.push_back(rise);
            nb = 0;
          end else begin
            nb++;
          end
        end
        prev_v = a_valid;
      end
    end
  end

  initial begin
    int          nb = 0;
    int          rise = 0;
    logic        prev_v = 1'b0;
    logic [63:0] cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        if (b_valid && !prev_v) rise = cyc;
        if (b_valid) begin
          cur[nb*8 +: 8] = b_data;
          if (nb == 7) begin
            frames_b.push_back(cur);
            starts_b.push_back(rise);
            nb = 0;
          end else begin
            nb++;
          end
        end
        prev_v = b_valid;
      end
    end
  end

  initial begin
    int c0;
    int d;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_last", 64'(a_last), 64'd0);
    chk("rst_data", 64'(a_data), 64'd0);
    chk("rst_busy", 64'(a_busy | b_busy), 64'd0);
    chk("rst_report", a_report, c_idle_rep);
    chk("rst_report_b", b_report, c_idle_rep);
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    busy_cnt = 0;

    // First report after reset is the idle report
    wait_frame(1, 100, "wait_idle_frame");
    chk("idle_frame", fa(0), c_idle_rep);
    repeat (3) @(negedge clk);
    chk("busy_cycles", 64'(busy_cnt), 64'd8);
    chk("idle_oreport", a_report, c_idle_rep);

    // R+A with two-cycle latency
    repeat (6100) @(posedge clk);
    #2;
    btn = 8'h81;
    c0 = cyc;
    wait_frame(2, 100, "wait_ra_frame");
    chk("ra_frame", fa(1), c_rep_ra);
    chk("ra_latency", 64'(sa(1) - c0), 64'd2);
    chk("ra_oreport", a_report, c_rep_ra);

    // start+select with ready toggling
    repeat (6100) @(posedge clk);
    #2;
    xfers = 0;
    tog = 1'b1;
    btn = 8'h0C;
    wait_frame(3, 200, "wait_ss_frame");
    repeat (20) @(negedge clk);
    tog = 1'b0;
    rdy = 1'b1;
    chk("ss_frame", fa(2), c_rep_ss);
    chk("ss_xfers", 64'(xfers), 64'd8);

    // Change during SEND does not alter report in flight
    repeat (6100) @(posedge clk);
    #2;
    btn = 8'h01;
    repeat (4) @(posedge clk);
    #2;
    btn = 8'h02;
    wait_frame(5, 7000, "wait_ab_frames");
    chk("inflight_frame", fa(3), c_rep_a);
    chk("after_gap_frame", fa(4), c_rep_b);
    d = sa(4) - sa(3);
    chk("gap_spacing", 64'(d >= 6000 && d <= 6003), 64'd1);

    // Reset while byte3 is on the bus
    repeat (6100) @(posedge clk);
    #2;
    btn = 8'h20;
    repeat (5) @(posedge clk);
    #2;
    rst_a = 1'b1;
    btn = 8'h00;
    @(negedge clk);
    chk("mid_valid_pre", 64'(a_valid), 64'd1);
    @(negedge clk);
    chk("mid_valid_drop", 64'(a_valid), 64'd0);
    chk("mid_no_frame", 64'(frames_a.size()), 64'd5);
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    wait_frame(6, 100, "wait_post_rst");
    chk("post_rst_frame", fa(5), c_idle_rep);

    // Idle resend on dut_b (constant Up)
    chk("b_frame_count", 64'(frames_b.size() >= 4), 64'd1);
    chk("b_first", fb(0), c_idle_rep);
    chk("b_up1", fb(1), c_rep_u);
    chk("b_up2", fb(2), c_rep_u);
    chk("b_up3", fb(3), c_rep_u);
    chk("b_spacing1", 64'(sb(2) - sb(1)), 64'd6000);
    chk("b_spacing2", 64'(sb(3) - sb(2)), 64'd6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
